// File: rtl/label_fb_pkg.sv
// label_fb_pkg: shared state encoding and default geometry for the label frame buffer.
package label_fb_pkg;
    typedef enum logic [1:0] {IDLE, CLEAR, DONE} fb_state_e;
    localparam int LBL_W = 3;
    localparam int FB_H = 320;
    localparam int FB_V = 240;
endpackage

// File: rtl/label_fb_mem.sv
// label_fb_mem: plain single-write, registered-read label array with no reset (BRAM-inferable).
module label_fb_mem #(
    parameter int DATA_W = 3,
    parameter int DEPTH = 76800,
    parameter int ADDR_W = 17
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic              re,
    input  logic [ADDR_W-1:0] raddr,
    output logic [DATA_W-1:0] rdata
);
    localparam int IDX_W = $clog2(DEPTH);
    logic [DATA_W-1:0] mem [DEPTH];
    always_ff @(posedge clk) begin
        if (we) mem[waddr[IDX_W-1:0]] <= wdata;
        if (re) rdata <= mem[raddr[IDX_W-1:0]];
    end
endmodule

// File: rtl/label_frame_buffer.sv
// label_frame_buffer: label store with clear engine, write-first forwarding and range checks.
// Define LABEL_FRAME_BUFFER_OUTREG_EN to add an output register (read latency 2).
module label_frame_buffer
    import label_fb_pkg::*;
#(
    parameter int DATA_W = LBL_W,
    parameter int H_RES = FB_H,
    parameter int V_RES = FB_V,
    parameter int ADDR_W = $clog2(H_RES * V_RES),
    parameter logic [DATA_W-1:0] CLR_VAL = '0,
    parameter bit INIT_CLEAR = 1'b1
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    output logic              wr_drop,
    input  logic              rd_en,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_valid,
    input  logic              clr_start,
    output logic              clr_busy,
    output logic              clr_done
);
    localparam int DEPTH = H_RES * V_RES;
    localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W + 1)'(DEPTH);
    localparam logic [ADDR_W-1:0] LAST = ADDR_W'(DEPTH - 1);
    fb_state_e state, state_n;
    logic [ADDR_W-1:0] clr_addr, clr_addr_n, mem_waddr;
    logic [DATA_W-1:0] mem_wdata, mem_rdata, fwd_val, fwd_val_n, rd_data_1;
    logic wr_in, rd_in, wr_ok, mem_we, mem_re, fwd_n, fwd_q, rd_valid_1;
    assign wr_in = {1'b0, wr_addr} < DEPTH_C;
    assign rd_in = {1'b0, rd_addr} < DEPTH_C;
    always_comb begin
        state_n = (state == IDLE && clr_start) ? CLEAR :
                  (state == CLEAR && clr_addr == LAST) ? DONE :
                  (state == DONE) ? IDLE : state;
        clr_addr_n = (state != CLEAR) ? '0 : (clr_addr == LAST) ? clr_addr : clr_addr + ADDR_W'(1);
        wr_ok = wr_en && wr_in && (state == DONE || (state == IDLE && !clr_start));
        mem_we = (state == CLEAR) || wr_ok;
        mem_waddr = (state == CLEAR) ? clr_addr : wr_addr;
        mem_wdata = (state == CLEAR) ? CLR_VAL : wr_data;
        // out-of-range reads and reads colliding with this cycle's write bypass the array
        fwd_n = !rd_in || (mem_we && mem_waddr == rd_addr);
        fwd_val_n = rd_in ? mem_wdata : CLR_VAL;
        mem_re = rd_en && !fwd_n;
        clr_busy = (state == CLEAR);
        clr_done = (state == DONE);
    end
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state <= INIT_CLEAR ? CLEAR : IDLE;
            clr_addr <= '0;
            wr_drop <= 1'b0;
            rd_valid_1 <= 1'b0;
            fwd_q <= 1'b1;
            fwd_val <= '0;
        end else begin
            state <= state_n;
            clr_addr <= clr_addr_n;
            wr_drop <= wr_en && !wr_ok;
            rd_valid_1 <= rd_en;
            if (rd_en) begin
                fwd_q <= fwd_n;
                fwd_val <= fwd_val_n;
            end
        end
    end
    assign rd_data_1 = fwd_q ? fwd_val : mem_rdata;
    label_fb_mem #(.DATA_W(DATA_W), .DEPTH(DEPTH), .ADDR_W(ADDR_W)) u_mem (
        .clk(clk),
        .we(mem_we),
        .waddr(mem_waddr),
        .wdata(mem_wdata),
        .re(mem_re),
        .raddr(rd_addr),
        .rdata(mem_rdata)
    );
`ifdef LABEL_FRAME_BUFFER_OUTREG_EN
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            rd_data <= '0;
            rd_valid <= 1'b0;
        end else begin
            rd_data <= rd_data_1;
            rd_valid <= rd_valid_1;
        end
    end
`else
    assign rd_data = rd_data_1;
    assign rd_valid = rd_valid_1;
`endif
endmodule
